move_place_ctrl: RTL and testbench
==================================

# move_place_ctrl

Move-placement controller for the 15x15 gobang board. It accepts a placement request at a (row, col) cursor and rejects illegal moves. It keeps the black and white stone bitmaps and alternates turns. After each legal move it presents the mover's bitmap and the move coordinates to the directional win checkers, then samples their combined verdict and ends the game on a five-in-a-row or a full board. It sits directly upstream of the four direction win-check blocks, which consume `chk_row`, `chk_col` and `chk_ch`.

## Interface
Parameters: none. Board size is fixed at 15x15, giving 225 cells.

Ports:
- `clk`  in  1  — system clock.
- `rst`  in  1  — reset, synchronous, active-high. It clears all state.
- `new_game`  in  1  — synchronous game restart. It clears the board, counters and result.
- `place_req`  in  1  — one-cycle request to place a stone at `row`/`col` for the side to move.
- `row`  in  4  — cursor row, legal range 0..14.
- `col`  in  4  — cursor column, legal range 0..14.
- `win_in`  in  1  — OR of all four direction win checkers, driven combinationally from `chk_*`.
- `black_ch`  out  225  — black stone bitmap; bit `row*15+col`.
- `white_ch`  out  225  — white stone bitmap; same indexing as `black_ch`.
- `chk_row`  out  4  — row of the last legal move.
- `chk_col`  out  4  — column of the last legal move.
- `chk_ch`  out  225  — bitmap of the side that made the last legal move (black or white).
- `chk_valid`  out  1  — high for exactly the cycle in which `win_in` is sampled.
- `turn`  out  1  — side to move; 0 = black, 1 = white.
- `busy`  out  1  — high when state is not IDLE.
- `illegal`  out  1  — one-cycle pulse when a request is rejected.
- `move_count`  out  8  — number of stones on the board, 0..225.
- `game_over`  out  1  — game finished; further requests are ignored.
- `winner`  out  2  — result code: 00 none, 01 black, 10 white, 11 draw.

## Operation
- Cell index: `idx = row*15 + col`. It is computed 8 bits wide, with a maximum of 224.
- States:
  - IDLE: accepts `place_req`.
  - CHECK: one cycle; `chk_valid`=1.
  - DONE: game ended.
- IDLE with `place_req`=1:
  - Illegal move: `row`>14, or `col`>14, or the cell is already set in either bitmap. The block pulses `illegal`, changes no state and stays in IDLE.
  - Legal move: the block sets bit `idx` in the mover's bitmap, loads `chk_row`/`chk_col`, increments `move_count` and goes to CHECK.
- CHECK: `chk_ch` already shows the updated mover bitmap. `win_in` is sampled at the end of this cycle, with this priority:
  - `win_in`=1: `winner` = mover (01 or 10), `game_over`=1, go to DONE.
  - Otherwise, if `move_count`==225: `winner`=11, `game_over`=1, go to DONE.
  - Otherwise: toggle `turn`, go to IDLE.
- `win_in` is ignored outside CHECK. The checkers hold stale or latched values between moves.
- DONE: `place_req` is ignored and `illegal` stays low. The block leaves DONE only on `new_game` or `rst`.
- `chk_ch` is a mux of `black_ch`/`white_ch`, selected by `turn` as registered during CHECK and DONE (the mover). Before the first move it is all zeros.
- Priority: `rst` > `new_game` > `place_req`. If `new_game` arrives together with `place_req`, the request is dropped.

## Timing
- Reset and `new_game` values: both bitmaps 0; `chk_row`=0; `chk_col`=0; `chk_valid`=0; `turn`=0; `busy`=0; `illegal`=0; `move_count`=0; `game_over`=0; `winner`=00; state IDLE.
- A request sampled at edge N produces:
  - bitmap, `move_count` and `chk_*` updated after edge N;
  - `chk_valid`=1 and `busy`=1 during cycle N+1;
  - verdict registered at edge N+1, with `turn`/`game_over`/`winner` valid from N+2.
- Per-move latency is 2 cycles. The earliest next accepted request is sampled at edge N+2.
- `illegal` is high for the single cycle after the rejecting edge.
- `place_req` during CHECK is ignored and produces no `illegal` pulse.
- `new_game` during CHECK aborts the move: the board clears and no verdict is recorded.
- All outputs are registered except `chk_ch` and `busy`, which are decoded from registered state only.

## Test plan
- Reset: assert `rst` for 2 cycles -> all outputs 0, `turn`=0, state IDLE.
- Place (7,7): one request -> `black_ch[112]`=1, `chk_row`=7, `chk_col`=7, `chk_valid` high for 1 cycle. With `win_in`=0, this gives `turn`=1 and `move_count`=1.
- Illegal moves:
  - Place (7,7) again -> `illegal` pulses, both bitmaps unchanged, `turn`=1.
  - Request with `col`=15 -> `illegal` pulses, `move_count` unchanged.
- Anti-diagonal win:
  - Black plays (4,0), (3,1), (2,2), (1,3), with white interleaved elsewhere.
  - Black then plays (0,4), with `win_in` driven by the real anti-diagonal checker, which fires on bits 60, 46, 32, 18, 4.
  - Required: `winner`=01, `game_over`=1, and a subsequent `place_req` is ignored with no `illegal` pulse.
- Draw: fill all 225 cells with `win_in` forced to 0 -> after the 225th move, `winner`=11, `game_over`=1, `move_count`=225.
- Restart: assert `new_game` in the CHECK cycle, together with `win_in`=1 -> board cleared, `winner`=00, state IDLE. Also assert `new_game` and `place_req` in the same cycle -> no stone is placed.

Source files
------------

// File: rtl/move_place_ctrl.sv
// move_place_ctrl: move-placement controller for a 15x15 gobang board.
// Validates placement requests and holds the black and white stone
// bitmaps. It alternates turns and hands each legal move to the direction
// win checkers. It records the verdict as a win or a draw on a full board.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   new_game            synchronous restart (clears board, counters, result)
//   place_req, row, col placement request at cursor (row, col)
//   win_in              combined verdict of the direction win checkers
//   black_ch, white_ch  stone bitmaps, bit row*15+col
//   chk_row, chk_col    coordinates of the last legal move
//   chk_ch              bitmap of the side that made the last legal move
//   chk_valid           high in the cycle win_in is sampled
//   turn                side to move (0 black, 1 white)
//   busy                state is not IDLE
//   illegal             one-cycle pulse on a rejected request
//   move_count          stones on the board
//   game_over, winner   result (00 none, 01 black, 10 white, 11 draw)
module move_place_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         new_game,
    input  logic         place_req,
    input  logic [3:0]   row,
    input  logic [3:0]   col,
    input  logic         win_in,
    output logic [224:0] black_ch,
    output logic [224:0] white_ch,
    output logic [3:0]   chk_row,
    output logic [3:0]   chk_col,
    output logic [224:0] chk_ch,
    output logic         chk_valid,
    output logic         turn,
    output logic         busy,
    output logic         illegal,
    output logic [7:0]   move_count,
    output logic         game_over,
    output logic [1:0]   winner
);

    localparam int unsigned SIDE  = 15;
    localparam int unsigned CELLS = SIDE * SIDE;
    localparam int unsigned IW    = 8;
    localparam int unsigned CW    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [IW-1:0]    idx;
    logic             in_range;
    logic [CELLS-1:0] cell_mask;
    logic             cell_taken;
    logic             legal;
    logic             board_full;

    // Request decode: cell index, one-hot cell mask and legality.
    // An out-of-range index shifts the mask to all zeros, so no
    // out-of-range bit select is needed.
    always_comb begin
        idx        = '0;
        in_range   = 1'b0;
        cell_mask  = '0;
        cell_taken = 1'b0;
        legal      = 1'b0;
        in_range   = (row < 4'(SIDE)) && (col < 4'(SIDE));
        idx        = IW'(row) * IW'(SIDE) + IW'(col);
        cell_mask  = CELLS'(1) << idx;
        cell_taken = |((black_ch | white_ch) & cell_mask);
        legal      = in_range && !cell_taken;
    end

    assign board_full = (move_count == CW'(CELLS));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; new_game overrides everything except reset.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (place_req && legal) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (win_in || board_full) begin
                    state_next = DONE;
                end else begin
                    state_next = IDLE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (new_game) begin
            state_next = IDLE;
        end
    end

    // Decoded outputs. In CHECK and DONE the turn has not yet toggled, so
    // it still names the mover.
    always_comb begin
        busy   = 1'b0;
        chk_ch = '0;
        busy   = (state != IDLE);
        if (state == CHECK || state == DONE) begin
            chk_ch = turn ? white_ch : black_ch;
        end
    end

    // Board, move bookkeeping and verdict registers.
    always_ff @(posedge clk) begin
        if (rst || new_game) begin
            black_ch   <= '0;
            white_ch   <= '0;
            chk_row    <= '0;
            chk_col    <= '0;
            chk_valid  <= 1'b0;
            turn       <= 1'b0;
            illegal    <= 1'b0;
            move_count <= '0;
            game_over  <= 1'b0;
            winner     <= 2'b00;
        end else begin
            illegal   <= 1'b0;
            chk_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (place_req) begin
                        if (legal) begin
                            if (turn) begin
                                white_ch <= white_ch | cell_mask;
                            end else begin
                                black_ch <= black_ch | cell_mask;
                            end
                            chk_row    <= row;
                            chk_col    <= col;
                            move_count <= move_count + CW'(1);
                            chk_valid  <= 1'b1;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (win_in) begin
                        winner    <= {turn, ~turn};
                        game_over <= 1'b1;
                    end else if (board_full) begin
                        winner    <= 2'b11;
                        game_over <= 1'b1;
                    end else begin
                        turn <= ~turn;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_place_ctrl.sv
// Self-checking bench for move_place_ctrl against a board-array model.
module tb_move_place_ctrl;

    logic         clk;
    logic         rst;
    logic         new_game;
    logic         place_req;
    logic [3:0]   row;
    logic [3:0]   col;
    logic         win_in;
    logic [224:0] black_ch;
    logic [224:0] white_ch;
    logic [3:0]   chk_row;
    logic [3:0]   chk_col;
    logic [224:0] chk_ch;
    logic         chk_valid;
    logic         turn;
    logic         busy;
    logic         illegal;
    logic [7:0]   move_count;
    logic         game_over;
    logic [1:0]   winner;

    move_place_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .new_game   (new_game),
        .place_req  (place_req),
        .row        (row),
        .col        (col),
        .win_in     (win_in),
        .black_ch   (black_ch),
        .white_ch   (white_ch),
        .chk_row    (chk_row),
        .chk_col    (chk_col),
        .chk_ch     (chk_ch),
        .chk_valid  (chk_valid),
        .turn       (turn),
        .busy       (busy),
        .illegal    (illegal),
        .move_count (move_count),
        .game_over  (game_over),
        .winner     (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 empty, 1 black, 2 white.
    int       board [15][15];
    int       m_turn;
    int       m_count;
    int       m_over;
    int       m_winner;
    int       ord [225];

    task automatic check_val(input string tag, input logic [224:0] got,
                             input logic [224:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [224:0] bmap(input int color);
        logic [224:0] m;
        m = '0;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++)
                if (board[r][c] == color) m[r*15+c] = 1'b1;
        return m;
    endfunction

    // Anti-diagonal five-in-a-row through (r,c) on a bitmap.
    function automatic bit anti_win(input logic [224:0] m, input int r, input int c);
        int  n;
        bit  run;
        n = 1;
        run = 1'b1;
        for (int k = 1; k < 5; k++) begin
            if (run && r - k >= 0 && c + k <= 14 && m[(r-k)*15 + c + k]) n++;
            else run = 1'b0;
        end
        run = 1'b1;
        for (int k = 1; k < 5; k++) begin
            if (run && r + k <= 14 && c - k >= 0 && m[(r+k)*15 + c - k]) n++;
            else run = 1'b0;
        end
        return n >= 5;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++)
                board[r][c] = 0;
        m_turn = 0;
        m_count = 0;
        m_over = 0;
        m_winner = 0;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, ":black"}, black_ch, bmap(1));
        check_val({tag, ":white"}, white_ch, bmap(2));
        check_val({tag, ":count"}, 225'(move_count), 225'(m_count));
        check_val({tag, ":turn"}, 225'(turn), 225'(m_turn));
        check_val({tag, ":over"}, 225'(game_over), 225'(m_over));
        check_val({tag, ":winner"}, 225'(winner), 225'(m_winner));
    endtask

    // One request, called at a negedge. mode 0: win_in forced to fwin;
    // mode 1: win_in from an anti-diagonal checker fed by chk_*.
    task automatic do_req(input int r, input int c, input int mode, input bit fwin);
        bit is_legal;
        bit exp_win;
        int mover;
        is_legal = (r <= 14) && (c <= 14);
        if (is_legal) is_legal = (board[r][c] == 0);
        place_req = 1'b1;
        row = 4'(r);
        col = 4'(c);
        @(negedge clk);
        place_req = 1'b0;
        if (m_over != 0) begin
            check_val("done_illegal", 225'(illegal), 225'(0));
            check_val("done_busy", 225'(busy), 225'(1));
            check_state("done");
        end else if (!is_legal) begin
            check_val("illegal", 225'(illegal), 225'(1));
            check_val("illegal_busy", 225'(busy), 225'(0));
            check_state("rej");
        end else begin
            mover = m_turn + 1;
            board[r][c] = mover;
            m_count++;
            check_val("chk_valid", 225'(chk_valid), 225'(1));
            check_val("chk_busy", 225'(busy), 225'(1));
            check_val("chk_illegal", 225'(illegal), 225'(0));
            check_val("chk_row", 225'(chk_row), 225'(r));
            check_val("chk_col", 225'(chk_col), 225'(c));
            check_val("chk_ch", chk_ch, bmap(mover));
            check_val("chk_black", black_ch, bmap(1));
            check_val("chk_white", white_ch, bmap(2));
            if (mode == 1) begin
                win_in = anti_win(chk_ch, int'(chk_row), int'(chk_col));
                exp_win = anti_win(bmap(mover), r, c);
            end else begin
                win_in = fwin;
                exp_win = fwin;
            end
            @(negedge clk);
            win_in = 1'b0;
            if (exp_win) begin
                m_winner = mover;
                m_over = 1;
            end else if (m_count == 225) begin
                m_winner = 3;
                m_over = 1;
            end else begin
                m_turn = 1 - m_turn;
            end
            check_val("post_valid", 225'(chk_valid), 225'(0));
            check_val("post_busy", 225'(busy), 225'(m_over));
            check_state("post");
        end
    endtask

    task automatic do_new_game();
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        check_val("ng_busy", 225'(busy), 225'(0));
        check_state("ng");
    endtask

    initial begin
        rst = 1'b1;
        new_game = 1'b0;
        place_req = 1'b0;
        row = '0;
        col = '0;
        win_in = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        check_val("rst_chk_row", 225'(chk_row), 225'(0));
        check_val("rst_chk_col", 225'(chk_col), 225'(0));
        check_val("rst_chk_valid", 225'(chk_valid), 225'(0));
        check_val("rst_chk_ch", chk_ch, '0);
        check_val("rst_busy", 225'(busy), 225'(0));
        check_val("rst_illegal", 225'(illegal), 225'(0));
        check_state("rst");

        // First move and illegal requests
        do_req(7, 7, 0, 1'b0);
        check_val("b112", 225'(black_ch[112]), 225'(1));
        do_req(7, 7, 0, 1'b0);
        do_req(3, 15, 0, 1'b0);
        do_req(15, 2, 0, 1'b0);

        // Randomized requests, checkers quiet
        for (int i = 0; i < 40; i++)
            do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0, 1'b0);

        // Anti-diagonal black win
        do_new_game();
        do_req(4, 0, 1, 1'b0);
        do_req(10, 10, 1, 1'b0);
        do_req(3, 1, 1, 1'b0);
        do_req(10, 11, 1, 1'b0);
        do_req(2, 2, 1, 1'b0);
        do_req(10, 12, 1, 1'b0);
        do_req(1, 3, 1, 1'b0);
        do_req(11, 0, 1, 1'b0);
        do_req(0, 4, 1, 1'b0);
        check_val("adiag_winner", 225'(winner), 225'(1));
        do_req(8, 8, 1, 1'b0);
        do_req(9, 9, 0, 1'b1);

        // Draw: full board in random order, win_in held low
        do_new_game();
        for (int i = 0; i < 225; i++) ord[i] = i;
        for (int i = 224; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(0, i));
            t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
        for (int i = 0; i < 225; i++) do_req(ord[i] / 15, ord[i] % 15, 0, 1'b0);
        check_val("draw_winner", 225'(winner), 225'(3));
        check_val("draw_count", 225'(move_count), 225'(225));
        do_req(0, 0, 0, 1'b0);

        // new_game in the CHECK cycle overrides a winning verdict
        do_new_game();
        place_req = 1'b1;
        row = 4'd5;
        col = 4'd5;
        @(negedge clk);
        place_req = 1'b0;
        check_val("abort_valid", 225'(chk_valid), 225'(1));
        new_game = 1'b1;
        win_in = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        win_in = 1'b0;
        check_val("abort_busy", 225'(busy), 225'(0));
        check_state("abort");
        @(negedge clk);
        check_val("abort_idle", 225'(busy), 225'(0));
        check_val("abort_winner", 225'(winner), 225'(0));

        // new_game with place_req in the same cycle drops the request
        do_req(2, 3, 0, 1'b0);
        new_game = 1'b1;
        place_req = 1'b1;
        row = 4'd6;
        col = 4'd6;
        @(negedge clk);
        new_game = 1'b0;
        place_req = 1'b0;
        model_clear();
        check_val("ngreq_busy", 225'(busy), 225'(0));
        check_val("ngreq_illegal", 225'(illegal), 225'(0));
        check_val("ngreq_valid", 225'(chk_valid), 225'(0));
        check_state("ngreq");
        @(negedge clk);
        check_val("ngreq_busy2", 225'(busy), 225'(0));
        check_state("ngreq2");

        // Play continues normally after the restart
        do_req(6, 6, 0, 1'b0);
        do_req(6, 7, 0, 1'b1);
        check_val("white_win", 225'(winner), 225'(2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
